// File: rtl/edge_propagator_tx_multi.sv
// Transmit side of a multi-channel edge propagator.
// Counts single-cycle events per channel and picks pending channels round-robin.
// Each event goes to a remote domain over a req/ack handshake (2- or 4-phase).
// Ack is synchronised locally; completion pulses, pending counts and overflow flags are exported.
module edge_propagator_tx_multi #(
  parameter int NumChannels = 4,
  parameter int CntWidth    = 4,
  parameter int SyncStages  = 2,
  parameter int FourPhase   = 1,
  localparam int ChW        = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumChannels-1:0]          edge_i,
  input  logic                            clr_ovf_i,
  output logic                            req_o,
  output logic [ChW-1:0]                  ch_o,
  input  logic                            ack_i,
  output logic [NumChannels-1:0]          ack_tx_o,
  output logic [NumChannels*CntWidth-1:0] pending_o,
  output logic [NumChannels-1:0]          overflow_o,
  output logic                            busy_o
);

  localparam int SW = ChW + 1;
  localparam logic [CntWidth-1:0] CntMax = '1;

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  state_t                 state, state_next;
  logic                   req, req_next;
  logic [ChW-1:0]         ch, ch_next;
  logic [ChW-1:0]         ptr, ptr_next;
  logic [SyncStages-1:0]  sync;
  logic                   ack_s;
  logic                   done;
  logic [NumChannels-1:0] done_vec;
  logic [NumChannels-1:0] nz;
  logic [NumChannels-1:0] ack_tx;
  logic                   grant_valid;
  logic [ChW-1:0]         grant_ch;
  logic [SW-1:0]          idx_sum;
  logic [SW-1:0]          ptr_sum;

  assign ack_s = sync[SyncStages-1];

  // Bring the asynchronous ack into the local clock domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync <= '0;
    else         sync <= {sync[SyncStages-2:0], ack_i};
  end

  // Per-channel pending counters and sticky overflow flags.
  for (genvar gi = 0; gi < NumChannels; gi++) begin : g_ch
    logic [CntWidth-1:0] cnt;
    logic                ovf;
    logic                ovf_set;

    assign done_vec[gi] = done && (ch == ChW'(gi));
    assign ovf_set      = edge_i[gi] && !done_vec[gi] && (cnt == CntMax);
    assign nz[gi]       = |cnt;
    assign pending_o[gi*CntWidth +: CntWidth] = cnt;
    assign overflow_o[gi] = ovf;

    // Count up on an event and down on a completion; saturate at the maximum.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        if (edge_i[gi] && !done_vec[gi]) begin
          if (cnt != CntMax) cnt <= cnt + 1'b1;
        end else if (!edge_i[gi] && done_vec[gi]) begin
          cnt <= cnt - 1'b1;
        end
        if (ovf_set)        ovf <= 1'b1;
        else if (clr_ovf_i) ovf <= 1'b0;
      end
    end
  end

  // Round-robin search upward from the pointer; lowest offset wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    idx_sum     = '0;
    for (int i = NumChannels - 1; i >= 0; i--) begin
      idx_sum = {1'b0, ptr} + SW'(i);
      if (idx_sum >= SW'(NumChannels)) idx_sum = idx_sum - SW'(NumChannels);
      if (nz[idx_sum[ChW-1:0]]) begin
        grant_valid = 1'b1;
        grant_ch    = idx_sum[ChW-1:0];
      end
    end
    ptr_sum = {1'b0, grant_ch} + SW'(1);
    if (ptr_sum >= SW'(NumChannels)) ptr_sum = '0;
  end

  // Handshake FSM next-state and output logic.
  always_comb begin
    state_next = state;
    req_next   = req;
    ch_next    = ch;
    ptr_next   = ptr;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          ch_next    = grant_ch;
          ptr_next   = ptr_sum[ChW-1:0];
          req_next   = (FourPhase != 0) ? 1'b1 : ~req;
          state_next = REQ;
        end
      end
      REQ: begin
        if (FourPhase != 0) begin
          if (ack_s) begin
            done       = 1'b1;
            req_next   = 1'b0;
            state_next = REL;
          end
        end else if (ack_s == req) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      REL: begin
        if (!ack_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, request, channel id, arbitration pointer and completion pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      req    <= 1'b0;
      ch     <= '0;
      ptr    <= '0;
      ack_tx <= '0;
    end else begin
      state  <= state_next;
      req    <= req_next;
      ch     <= ch_next;
      ptr    <= ptr_next;
      ack_tx <= done_vec;
    end
  end

  assign req_o    = req;
  assign ch_o     = ch;
  assign ack_tx_o = ack_tx;
  assign busy_o   = (state != IDLE);

  // A remote ack must never rise while no request is outstanding.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !((state == IDLE) && $rose(ack_s)));

endmodule

// File: tb/tb_edge_propagator_tx_multi.sv
// Directed bench for edge_propagator_tx_multi: a 4-phase and a 2-phase instance,
// each driven by a small remote model that echoes req onto ack after a delay.
module tb_edge_propagator_tx_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [3:0]  edge4 = '0, acktx4, ovf4;
  logic        clr4 = 1'b0, req4, ack4, busy4;
  logic [1:0]  ch4;
  logic [15:0] pend4;

  logic [3:0]  edge2 = '0, acktx2, ovf2;
  logic        clr2 = 1'b0, req2, ack2, busy2;
  logic [1:0]  ch2;
  logic [15:0] pend2;

  // remote models
  logic       ack_auto4, ack_auto2;
  logic [1:0] dly4, dly2;
  logic       hold4 = 1'b0, man4 = 1'b0, man_ack4 = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign ack4 = man4 ? man_ack4 : ack_auto4;
  assign ack2 = ack_auto2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_auto4 <= 1'b0; dly4 <= '0;
    end else if (ack_auto4 != req4 && !hold4) begin
      if (dly4 == 2'd2) begin ack_auto4 <= req4; dly4 <= '0; end
      else dly4 <= dly4 + 2'd1;
    end else dly4 <= '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_auto2 <= 1'b0; dly2 <= '0;
    end else if (ack_auto2 != req2) begin
      if (dly2 == 2'd2) begin ack_auto2 <= req2; dly2 <= '0; end
      else dly2 <= dly2 + 2'd1;
    end else dly2 <= '0;
  end

  edge_propagator_tx_multi #(.NumChannels(4), .CntWidth(4), .SyncStages(2), .FourPhase(1)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .edge_i(edge4), .clr_ovf_i(clr4), .req_o(req4), .ch_o(ch4),
    .ack_i(ack4), .ack_tx_o(acktx4), .pending_o(pend4), .overflow_o(ovf4), .busy_o(busy4));

  edge_propagator_tx_multi #(.NumChannels(4), .CntWidth(4), .SyncStages(2), .FourPhase(0)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .edge_i(edge2), .clr_ovf_i(clr2), .req_o(req2), .ch_o(ch2),
    .ack_i(ack2), .ack_tx_o(acktx2), .pending_o(pend2), .overflow_o(ovf2), .busy_o(busy2));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    n_cmp++; if ({req4, ch4, acktx4, pend4, ovf4, busy4} !== 28'd0) begin n_bad++;
      $display("FAIL reset_4p got %h exp 0", {req4, ch4, acktx4, pend4, ovf4, busy4}); end
    n_cmp++; if ({req2, ch2, acktx2, pend2, ovf2, busy2} !== 28'd0) begin n_bad++;
      $display("FAIL reset_2p got %h exp 0", {req2, ch2, acktx2, pend2, ovf2, busy2}); end
    rst_n = 1'b1; tick();
    $display("reset released: req4=%0d busy4=%0d req2=%0d busy2=%0d", req4, busy4, req2, busy2);
  endtask

  task automatic test_single_4p();
    int pulses = 0;
    edge4 = 4'b0001; tick(); edge4 = '0;
    n_cmp++; if (pend4[3:0] !== 4'd1) begin n_bad++; $display("FAIL single_pend_t1 got %0d exp 1", pend4[3:0]); end
    n_cmp++; if (req4 !== 1'b0) begin n_bad++; $display("FAIL single_req_t1 got %0d exp 0", req4); end
    tick();
    n_cmp++; if (req4 !== 1'b1) begin n_bad++; $display("FAIL single_req_t2 got %0d exp 1", req4); end
    n_cmp++; if (ch4 !== 2'd0) begin n_bad++; $display("FAIL single_ch got %0d exp 0", ch4); end
    n_cmp++; if (busy4 !== 1'b1) begin n_bad++; $display("FAIL single_busy got %0d exp 1", busy4); end
    for (int i = 0; i < 40; i++) begin tick(); if (acktx4[0]) pulses++; end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL single_pulses got %0d exp 1", pulses); end
    n_cmp++; if ({pend4[3:0], busy4, req4} !== 6'd0) begin n_bad++;
      $display("FAIL single_idle got pend=%0d busy=%0d req=%0d exp 0", pend4[3:0], busy4, req4); end
    $display("single 4p: pulses=%0d pend0=%0d busy=%0d", pulses, pend4[3:0], busy4);
  endtask

  task automatic test_round_robin();
    int ord[5];
    int k = 0;
    pulse_reset();
    edge4 = 4'b0111; tick(); edge4 = '0;
    for (int i = 0; i < 120; i++) begin
      tick();
      for (int c = 0; c < 4; c++) if (acktx4[c]) begin
        if (k < 5) ord[k] = c;
        k++;
        n_cmp++; if (ch4 !== 2'(c)) begin n_bad++; $display("FAIL rr_ch_at_pulse got %0d exp %0d", ch4, c); end
      end
    end
    n_cmp++; if (k != 3) begin n_bad++; $display("FAIL rr_count got %0d exp 3", k); end
    else begin
      n_cmp++; if (ord[0] != 0 || ord[1] != 1 || ord[2] != 2) begin n_bad++;
        $display("FAIL rr_order got %0d,%0d,%0d exp 0,1,2", ord[0], ord[1], ord[2]); end
    end
    $display("rr first batch: %0d transfers", k);
    k = 0;
    edge4 = 4'b1001; tick(); edge4 = '0;
    for (int i = 0; i < 80; i++) begin
      tick();
      for (int c = 0; c < 4; c++) if (acktx4[c]) begin if (k < 5) ord[k] = c; k++; end
    end
    n_cmp++; if (k != 2) begin n_bad++; $display("FAIL rr2_count got %0d exp 2", k); end
    else begin
      n_cmp++; if (ord[0] != 3 || ord[1] != 0) begin n_bad++;
        $display("FAIL rr2_order got %0d,%0d exp 3,0", ord[0], ord[1]); end
    end
    $display("rr second batch: %0d transfers", k);
  endtask

  task automatic test_overflow();
    int pulses = 0;
    hold4 = 1'b1;
    edge4 = 4'b0010;
    for (int i = 0; i < 17; i++) tick();
    edge4 = '0; tick();
    n_cmp++; if (pend4[7:4] !== 4'd15) begin n_bad++; $display("FAIL ovf_sat got %0d exp 15", pend4[7:4]); end
    n_cmp++; if (ovf4 !== 4'b0010) begin n_bad++; $display("FAIL ovf_flag got %b exp 0010", ovf4); end
    hold4 = 1'b0;
    for (int i = 0; i < 400; i++) begin tick(); if (acktx4[1]) pulses++; end
    n_cmp++; if (pulses != 15) begin n_bad++; $display("FAIL ovf_drain got %0d exp 15", pulses); end
    n_cmp++; if (pend4 !== 16'd0) begin n_bad++; $display("FAIL ovf_pend_end got %h exp 0", pend4); end
    n_cmp++; if (ovf4 !== 4'b0010) begin n_bad++; $display("FAIL ovf_sticky got %b exp 0010", ovf4); end
    clr4 = 1'b1; tick(); clr4 = 1'b0;
    n_cmp++; if (ovf4 !== 4'b0000) begin n_bad++; $display("FAIL ovf_clear got %b exp 0000", ovf4); end
    $display("overflow: drained %0d, ovf after clear=%b", pulses, ovf4);
  endtask

  task automatic test_same_cycle();
    int pulses = 0;
    hold4 = 1'b1; man4 = 1'b1; man_ack4 = 1'b0;
    edge4 = 4'b0100; tick(); tick(); tick(); edge4 = '0; tick();
    n_cmp++; if (pend4[11:8] !== 4'd3) begin n_bad++; $display("FAIL same_pre_pend got %0d exp 3", pend4[11:8]); end
    n_cmp++; if (req4 !== 1'b1 || ch4 !== 2'd2) begin n_bad++;
      $display("FAIL same_pre_req got req=%0d ch=%0d exp req=1 ch=2", req4, ch4); end
    man_ack4 = 1'b1; tick(); tick();
    edge4 = 4'b0100; tick(); edge4 = '0;
    n_cmp++; if (acktx4 !== 4'b0100) begin n_bad++; $display("FAIL same_pulse got %b exp 0100", acktx4); end
    n_cmp++; if (pend4[11:8] !== 4'd3) begin n_bad++; $display("FAIL same_pend got %0d exp 3", pend4[11:8]); end
    man_ack4 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    man4 = 1'b0; hold4 = 1'b0;
    for (int i = 0; i < 200; i++) begin tick(); if (acktx4[2]) pulses++; end
    n_cmp++; if (pulses != 3 || pend4 !== 16'd0) begin n_bad++;
      $display("FAIL same_drain got pulses=%0d pend=%h exp 3 and 0", pulses, pend4); end
    $display("same-cycle: drained %0d more transfers", pulses);
  endtask

  task automatic test_two_phase();
    int toggles = 0, pulses = 0;
    logic prev;
    n_cmp++; if (req2 !== 1'b0) begin n_bad++; $display("FAIL 2p_req_init got %0d exp 0", req2); end
    prev = req2;
    edge2 = 4'b0001; tick(); tick(); tick(); edge2 = '0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (req2 !== prev) begin toggles++; prev = req2; end
      if (acktx2[0]) begin
        pulses++;
        n_cmp++; if (ack2 !== req2) begin n_bad++; $display("FAIL 2p_ack_match got ack=%0d exp %0d", ack2, req2); end
      end
    end
    n_cmp++; if (toggles != 3 || req2 !== 1'b1) begin n_bad++;
      $display("FAIL 2p_toggles got %0d final=%0d exp 3 final=1", toggles, req2); end
    n_cmp++; if (pulses != 3) begin n_bad++; $display("FAIL 2p_pulses got %0d exp 3", pulses); end
    n_cmp++; if (pend2 !== 16'd0 || busy2 !== 1'b0) begin n_bad++;
      $display("FAIL 2p_end got pend=%h busy=%0d exp 0", pend2, busy2); end
    $display("two-phase: toggles=%0d pulses=%0d", toggles, pulses);
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    hold4 = 1'b1;
    edge4 = 4'b1000; for (int i = 0; i < 16; i++) tick();
    edge4 = 4'b0001; for (int i = 0; i < 5; i++) tick();
    edge4 = '0; tick();
    n_cmp++; if (pend4[3:0] !== 4'd5 || pend4[15:12] !== 4'd15 || ovf4 !== 4'b1000) begin n_bad++;
      $display("FAIL ar_pre got pend=%h ovf=%b exp pend0=5 pend3=15 ovf=1000", pend4, ovf4); end
    n_cmp++; if (req4 !== 1'b1 || busy4 !== 1'b1) begin n_bad++;
      $display("FAIL ar_pre_busy got req=%0d busy=%0d exp 1,1", req4, busy4); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({req4, pend4, ovf4, busy4, ch4, acktx4} !== 28'd0) begin n_bad++;
      $display("FAIL ar_async got %h exp 0", {req4, pend4, ovf4, busy4, ch4, acktx4}); end
    tick(); rst_n = 1'b1; hold4 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_cmp++; if (req4 !== 1'b0 || busy4 !== 1'b0) begin n_bad++;
      $display("FAIL ar_quiet got req=%0d busy=%0d exp 0,0", req4, busy4); end
    edge4 = 4'b0001; tick(); edge4 = '0; tick();
    n_cmp++; if (req4 !== 1'b1) begin n_bad++; $display("FAIL ar_new_req got %0d exp 1", req4); end
    for (int i = 0; i < 40; i++) begin tick(); if (acktx4[0]) pulses++; end
    n_cmp++; if (pulses != 1 || busy4 !== 1'b0) begin n_bad++;
      $display("FAIL ar_new_done got pulses=%0d busy=%0d exp 1,0", pulses, busy4); end
    $display("async reset: post-reset transfers=%0d", pulses);
  endtask

  initial begin
    test_reset();
    test_single_4p();
    test_round_robin();
    test_overflow();
    test_same_cycle();
    test_two_phase();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
